// File: rtl/mcu_spi_pkg.sv
// ==== mcu_spi_pkg : shared MCU SPI link types and constants ==== rev 1.0 ====
`default_nettype none

package mcu_spi_pkg;

   localparam int SPI_BYTE_W = 8;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

   // Byte-boundary test shared by slave and master bit counters.
   function automatic logic at_byte_boundary(input logic [2:0] bit_cnt);
      return (bit_cnt == 3'd0);
   endfunction

endpackage : mcu_spi_pkg

`default_nettype wire

// File: rtl/mcu_spi_slave_sync_edge.sv
// ==== sync_edge : N-stage synchronizer with rise/fall pulses ==== rev 1.0 ====
`default_nettype none

module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Reset to 0 so a pin held low through reset never looks like a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule : sync_edge

`default_nettype wire

// File: rtl/mcu_spi_slave.sv
// ==== mcu_spi_slave : SPI mode-0 slave, oversampled in clk domain ==== rev 1.0 ====
`default_nettype none

module mcu_spi_slave
   import mcu_spi_pkg::*;
#(
   parameter int                   SYNC_STAGES = 2,
   parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  spi_cs,
   input  logic                  spi_sclk,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic [SPI_BYTE_W-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  rx_first,
   output logic                  frame_end,
   output logic                  frame_err,
   input  logic [SPI_BYTE_W-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready
);

   logic cs_level, cs_rise, cs_fall;
   logic sclk_level, sclk_rise, sclk_fall;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic mosi_s;

   sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (spi_cs),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (spi_sclk),
      .level (sclk_level),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_sync_q <= '0;
      end else begin
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      end
   end

   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   spi_state_e            state_q, state_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic                  first_q, first_d;
   logic [SPI_BYTE_W-1:0] rx_sr_q, rx_sr_d;
   logic [SPI_BYTE_W-1:0] tx_sr_q, tx_sr_d;
   logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  rx_first_q, rx_first_d;
   logic                  frame_end_q, frame_end_d;
   logic                  frame_err_q, frame_err_d;
   logic                  miso_q, miso_d;
   logic                  load_tx;
   logic [SPI_BYTE_W-1:0] tx_next;

   assign tx_next = tx_valid ? tx_data : IDLE_BYTE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         first_q     <= 1'b0;
         rx_sr_q     <= '0;
         tx_sr_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         rx_first_q  <= 1'b0;
         frame_end_q <= 1'b0;
         frame_err_q <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         first_q     <= first_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         rx_first_q  <= rx_first_d;
         frame_end_q <= frame_end_d;
         frame_err_q <= frame_err_d;
         miso_q      <= miso_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      first_d     = first_q;
      rx_sr_d     = rx_sr_q;
      tx_sr_d     = tx_sr_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      rx_first_d  = 1'b0;
      frame_end_d = 1'b0;
      frame_err_d = 1'b0;
      load_tx     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d   = ST_ACTIVE;
               bit_cnt_d = 3'd0;
               first_d   = 1'b1;
               rx_sr_d   = '0;
               load_tx   = 1'b1;
            end
         end

         ST_ACTIVE: begin
            // CS rise wins over any SCLK edge seen in the same cycle.
            if (cs_rise) begin
               state_d     = ST_IDLE;
               frame_end_d = 1'b1;
               frame_err_d = !at_byte_boundary(bit_cnt_q);
               bit_cnt_d   = 3'd0;
               rx_sr_d     = '0;
               first_d     = 1'b0;
            end else if (sclk_rise) begin
               rx_sr_d   = {rx_sr_q[SPI_BYTE_W-2:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d  = {rx_sr_q[SPI_BYTE_W-2:0], mosi_s};
                  rx_valid_d = 1'b1;
                  rx_first_d = first_q;
                  first_d    = 1'b0;
               end
            end else if (sclk_fall) begin
               if (at_byte_boundary(bit_cnt_q)) begin
                  load_tx = 1'b1;
               end else begin
                  tx_sr_d = {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (load_tx) begin
         tx_sr_d = tx_next;
      end

      miso_d = (state_q == ST_ACTIVE) ? tx_sr_q[SPI_BYTE_W-1] : 1'b0;
   end

   // tx_ready is combinational so the source sees it in the cycle tx_sr loads.
   assign tx_ready  = load_tx;
   assign spi_miso  = miso_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign rx_first  = rx_first_q;
   assign frame_end = frame_end_q;
   assign frame_err = frame_err_q;

endmodule : mcu_spi_slave

`default_nettype wire

// File: tb/tb_mcu_spi_slave.sv
// ==== tb_mcu_spi_slave : directed self-checking bench for mcu_spi_slave ==== rev 1.0 ====
`default_nettype none

module tb_mcu_spi_slave;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       spi_cs, spi_sclk, spi_mosi, spi_miso;
   logic [7:0] rx_data;
   logic       rx_valid, rx_first, frame_end, frame_err;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   int vectors = 0;
   int errs    = 0;

   logic [7:0] tx_mem [0:63];
   int         tx_used = 0;
   logic [7:0] rx_q [$];
   logic       rf_q [$];
   int         fe_cnt = 0;
   logic       last_ferr = 1'b0;
   int         txr_cnt = 0;

   always #5 clk = ~clk;

   mcu_spi_slave #(
      .SYNC_STAGES (2),
      .IDLE_BYTE   (8'hFF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_cs    (spi_cs),
      .spi_sclk  (spi_sclk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_first  (rx_first),
      .frame_end (frame_end),
      .frame_err (frame_err),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready)
   );

   assign tx_data = tx_mem[tx_used];

   always @(posedge clk) begin
      if (tx_ready && tx_valid) tx_used <= tx_used + 1;
   end

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_q.push_back(rx_data);
         rf_q.push_back(rx_first);
      end
      if (frame_end) begin
         fe_cnt    = fe_cnt + 1;
         last_ferr = frame_err;
      end
      if (tx_ready) txr_cnt = txr_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         errs = errs + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cs_low();
      @(negedge clk);
      spi_cs = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (4) @(negedge clk);
      spi_cs = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Mode 0: MOSI set while SCLK low, MISO sampled at the rising edge.
   task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = mo[7-i];
         repeat (4) @(negedge clk);
         mi = {mi[6:0], spi_miso};
         spi_sclk = 1'b1;
         repeat (4) @(negedge clk);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic clear_mon();
      rx_q.delete();
      rf_q.delete();
      fe_cnt  = 0;
      txr_cnt = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] mi0, mi1, mi2;
      int         fe_base;

      for (int k = 0; k < 64; k++) tx_mem[k] = 8'h00;
      rst_n    = 1'b0;
      spi_cs   = 1'b1;
      spi_sclk = 1'b0;
      spi_mosi = 1'b0;
      tx_valid = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_miso",      {31'd0, spi_miso},  32'd0);
      chk("rst_rx_data",   {24'd0, rx_data},   32'd0);
      chk("rst_rx_valid",  {31'd0, rx_valid},  32'd0);
      chk("rst_rx_first",  {31'd0, rx_first},  32'd0);
      chk("rst_frame_end", {31'd0, frame_end}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_tx_ready",  {31'd0, tx_ready},  32'd0);

      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      clear_mon();

      // Two-byte frame with tx source supplying 5A, C3.
      tx_mem[tx_used]     = 8'h5A;
      tx_mem[tx_used + 1] = 8'hC3;
      tx_valid = 1'b1;
      cs_low();
      xfer(8'hA5, 8, mi1);
      xfer(8'h3C, 8, mi2);
      cs_high();
      chk("t1_rx_count", rx_q.size(), 32'd2);
      if (rx_q.size() == 2) begin
         chk("t1_rx0",    {24'd0, rx_q[0]}, 32'hA5);
         chk("t1_first0", {31'd0, rf_q[0]}, 32'd1);
         chk("t1_rx1",    {24'd0, rx_q[1]}, 32'h3C);
         chk("t1_first1", {31'd0, rf_q[1]}, 32'd0);
      end
      chk("t1_miso0",    {24'd0, mi1}, 32'h5A);
      chk("t1_miso1",    {24'd0, mi2}, 32'hC3);
      chk("t1_fe_count", fe_cnt, 32'd1);
      chk("t1_ferr",     {31'd0, last_ferr}, 32'd0);
      chk("t1_rx_hold",  {24'd0, rx_data}, 32'h3C);

      // No tx source: IDLE_BYTE on every byte; load at start plus each byte boundary.
      clear_mon();
      tx_valid = 1'b0;
      cs_low();
      xfer(8'h12, 8, mi1);
      xfer(8'h34, 8, mi2);
      cs_high();
      chk("t2_miso0",   {24'd0, mi1}, 32'hFF);
      chk("t2_miso1",   {24'd0, mi2}, 32'hFF);
      chk("t2_txready", txr_cnt, 32'd3);
      chk("t2_rx_count", rx_q.size(), 32'd2);
      if (rx_q.size() == 2) chk("t2_rx1", {24'd0, rx_q[1]}, 32'h34);

      // Frame aborted after 5 bits, then a clean 8'h81 frame.
      clear_mon();
      cs_low();
      xfer(8'hF0, 5, mi0);
      cs_high();
      chk("t3_no_rx",   rx_q.size(), 32'd0);
      chk("t3_fe",      fe_cnt, 32'd1);
      chk("t3_ferr",    {31'd0, last_ferr}, 32'd1);
      cs_low();
      xfer(8'h81, 8, mi0);
      cs_high();
      chk("t3_rx_count", rx_q.size(), 32'd1);
      if (rx_q.size() == 1) begin
         chk("t3_rx81",    {24'd0, rx_q[0]}, 32'h81);
         chk("t3_first81", {31'd0, rf_q[0]}, 32'd1);
      end
      chk("t3_ferr2", {31'd0, last_ferr}, 32'd0);

      // SCLK activity with CS high must be invisible.
      clear_mon();
      for (int i = 0; i < 8; i++) begin
         spi_mosi = i[0];
         spi_sclk = 1'b1;
         repeat (4) @(negedge clk);
         chk("t4_idle_miso", {31'd0, spi_miso}, 32'd0);
         spi_sclk = 1'b0;
         repeat (4) @(negedge clk);
      end
      chk("t4_no_rx",  rx_q.size(), 32'd0);
      chk("t4_no_fe",  fe_cnt, 32'd0);
      chk("t4_no_txr", txr_cnt, 32'd0);
      chk("t4_rx_hold", {24'd0, rx_data}, 32'h81);

      // Reset after 3 bits of a byte, then a full 8'h7E frame.
      clear_mon();
      tx_valid = 1'b1;
      tx_mem[tx_used] = 8'h96;
      cs_low();
      xfer(8'hAA, 3, mi0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_miso",      {31'd0, spi_miso},  32'd0);
      chk("t5_rx_data",   {24'd0, rx_data},   32'd0);
      chk("t5_rx_valid",  {31'd0, rx_valid},  32'd0);
      chk("t5_rx_first",  {31'd0, rx_first},  32'd0);
      chk("t5_frame_end", {31'd0, frame_end}, 32'd0);
      chk("t5_frame_err", {31'd0, frame_err}, 32'd0);
      chk("t5_tx_ready",  {31'd0, tx_ready},  32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      xfer(8'h55, 5, mi0);
      cs_high();
      chk("t5_no_rx_after_rst", rx_q.size(), 32'd0);
      chk("t5_no_fe_after_rst", fe_cnt, 32'd0);
      cs_low();
      xfer(8'h7E, 8, mi0);
      cs_high();
      chk("t5_rx_count", rx_q.size(), 32'd1);
      if (rx_q.size() == 1) begin
         chk("t5_rx7e",    {24'd0, rx_q[0]}, 32'h7E);
         chk("t5_first7e", {31'd0, rf_q[0]}, 32'd1);
      end
      chk("t5_fe", fe_cnt, 32'd1);

      // SCLK = clk/8, CS high for only 3 cycles between two frames.
      clear_mon();
      tx_mem[tx_used]     = 8'h44;
      tx_mem[tx_used + 1] = 8'h55;
      tx_mem[tx_used + 2] = 8'h00;
      tx_mem[tx_used + 3] = 8'h66;
      cs_low();
      xfer(8'h11, 8, mi1);
      xfer(8'h22, 8, mi2);
      repeat (4) @(negedge clk);
      spi_cs = 1'b1;
      repeat (3) @(negedge clk);
      spi_cs = 1'b0;
      repeat (8) @(negedge clk);
      fe_base = fe_cnt;
      xfer(8'h33, 8, mi0);
      cs_high();
      chk("t6_miso0", {24'd0, mi1}, 32'h44);
      chk("t6_miso1", {24'd0, mi2}, 32'h55);
      chk("t6_miso2", {24'd0, mi0}, 32'h66);
      chk("t6_fe_gap", fe_base, 32'd1);
      chk("t6_fe_total", fe_cnt, 32'd2);
      chk("t6_ferr", {31'd0, last_ferr}, 32'd0);
      chk("t6_rx_count", rx_q.size(), 32'd3);
      if (rx_q.size() == 3) begin
         chk("t6_rx0", {24'd0, rx_q[0]}, 32'h11);
         chk("t6_rx1", {24'd0, rx_q[1]}, 32'h22);
         chk("t6_rx2", {24'd0, rx_q[2]}, 32'h33);
         chk("t6_flags", {29'd0, rf_q[0], rf_q[1], rf_q[2]}, 32'b101);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule : tb_mcu_spi_slave

`default_nettype wire
